// File: rtl/sar_adc_capture_pkg.sv
// Shared widths and FSM state encodings for the SAR ADC capture back-end.
package sar_adc_capture_pkg;

  localparam int ADC_DW       = 11;
  localparam int SAMPLE_CNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAPT = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_PUSH = 2'd3;

endpackage

// File: rtl/sar_adc_capture_if.sv
// Valid/ready result stream between the capture block and its consumer.
interface sar_adc_capture_if #(
  parameter int DW = 11
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sar_adc_capture_fifo.sv
// Small synchronous result FIFO; head word is presented combinationally, last popped word held when empty.
module sar_cap_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [DW-1:0] last_q;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & ~empty_o;
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sar_adc_capture.sv
// SAR ADC capture: READY synchroniser, rise detect, capture/average FSM, result FIFO.
// state | meaning: IDLE wait rise/pending | CAPT latch code | ACC accumulate | PUSH write FIFO
module sar_adc_capture
  import sar_adc_capture_pkg::*;
#(
  parameter int DW          = ADC_DW,
  parameter int AVG_LOG2    = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DW-1:0]           adc_b_i,
  input  logic                    adc_ready_i,
  input  logic                    avg_en_i,
  input  logic                    clr_ovf_i,
  sar_adc_capture_if.master       out_if,
  output logic                    overflow_o,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt_o
);
  localparam int AW = DW + AVG_LOG2;

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ready_dly_q;
  logic                    rise;
  logic [1:0]              state_q, state_d;
  logic [DW-1:0]           cap_q, cap_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [AVG_LOG2-1:0]     cnt_q, cnt_d;
  logic                    avg_q, avg_d;
  logic                    pending_q, pending_d;
  logic                    ovf_q, ovf_d;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic                    push, pop, full, empty, pend_drop;
  logic [DW-1:0]           word;

  assign rise      = sync_q[SYNC_STAGES-1] & ~ready_dly_q;
  assign push      = (state_q == ST_PUSH);
  assign pop       = out_if.valid & out_if.ready;
  assign pend_drop = rise & (state_q != ST_IDLE) & pending_q;
  assign word      = avg_q ? acc_q[AVG_LOG2 +: DW] : cap_q;

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    avg_d        = avg_q;
    pending_d    = pending_q;
    sample_cnt_d = sample_cnt_q;
    if (rise && state_q != ST_IDLE) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_CAPT;
          pending_d = rise;
        end else if (rise) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        cap_d        = adc_b_i;
        sample_cnt_d = sample_cnt_q + SAMPLE_CNT_W'(1);
        if (cnt_q == '0) avg_d = avg_en_i;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d   = acc_q + AW'(cap_q);
        cnt_d   = cnt_q + AVG_LOG2'(1);
        state_d = (!avg_q || (&cnt_q)) ? ST_PUSH : ST_IDLE;
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Setting the sticky flag takes priority over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if ((push & full & ~pop) | pend_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      ready_dly_q  <= 1'b0;
      state_q      <= ST_IDLE;
      cap_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      avg_q        <= 1'b0;
      pending_q    <= 1'b0;
      ovf_q        <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], adc_ready_i};
      ready_dly_q  <= sync_q[SYNC_STAGES-1];
      state_q      <= state_d;
      cap_q        <= cap_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      avg_q        <= avg_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  sar_cap_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (word),
    .pop_i   (pop),
    .data_o  (out_if.data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_if.valid = ~empty;
  assign overflow_o   = ovf_q;
  assign sample_cnt_o = sample_cnt_q;
endmodule
